// File: rtl/sync_ram_ctrl.sv
// Single-port synchronous RAM behind a valid/ready request port.
// Reads return in order through a 2-entry response FIFO. An optional zero-fill sweep runs after reset.
module sync_ram_ctrl #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32,
    parameter int LANE_WIDTH = 8,
    parameter int INIT_ZERO  = 1,
    localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_LANES-1:0]  req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy
);
    localparam int LENGTH = 2 ** ADDR_WIDTH;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   sweep_q, sweep_d;
    logic [1:0]              count_q, count_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0]   last_q, last_d;

    logic [DATA_WIDTH-1:0]   mem [0:LENGTH-1];
    logic [DATA_WIDTH-1:0]   rsp_buf [0:1];

    logic                    push;
    logic                    pop;
    logic [NUM_LANES-1:0]    mem_be;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        busy      = 1'b0;
        req_ready = 1'b0;
        push      = 1'b0;
        mem_be    = '0;
        mem_addr  = req_addr;
        mem_wdata = req_wdata;
        rsp_valid = (count_q != 2'd0);
        // Once the FIFO drains, the last popped word stays visible.
        rsp_rdata = rsp_valid ? rsp_buf[rd_ptr_q] : last_q;
        pop       = rsp_valid && rsp_ready;

        case (state_q)
            ST_INIT: begin
                busy      = 1'b1;
                mem_be    = '1;
                mem_addr  = sweep_q;
                mem_wdata = '0;
                sweep_d   = sweep_q + ADDR_WIDTH'(1);
                if (sweep_q == '1) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                // Reads may enter a full FIFO only when its head leaves on the same edge.
                req_ready = !rst && (req_we || (count_q < 2'd2) || pop);
                if (req_valid && req_ready) begin
                    if (req_we) begin
                        mem_be = req_be;
                    end else begin
                        push = 1'b1;
                    end
                end
            end
        endcase

        count_d  = count_q + 2'(push) - 2'(pop);
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        last_d   = pop ? rsp_buf[rd_ptr_q] : last_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
            sweep_q  <= '0;
            count_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            last_q   <= '0;
        end else begin
            state_q  <= state_d;
            sweep_q  <= sweep_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            last_q   <= last_d;
        end
    end

    // Storage is deliberately left out of reset; only the sweep clears it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (mem_be[i]) begin
                mem[mem_addr][i*LANE_WIDTH +: LANE_WIDTH] <= mem_wdata[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
        if (push) begin
            rsp_buf[wr_ptr_q] <= mem[req_addr];
        end
    end
endmodule

// File: tb/tb_sync_ram_ctrl.sv
// Randomized and directed bench for sync_ram_ctrl (16 words x 32 bits), checked against a queue/array model.
module tb_sync_ram_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [3:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        busy;

    sync_ram_ctrl #(
        .ADDR_WIDTH(4),
        .DATA_WIDTH(32),
        .LANE_WIDTH(8),
        .INIT_ZERO(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_be(req_be),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] model_mem [16];
    logic [31:0] exp_q [$];
    logic [31:0] last_rd = '0;
    int          init_left = 0;
    bit          last_acc = 1'b0;

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: compare outputs at the falling edge, then advance the model past the rising edge.
    task automatic step();
        bit exp_rdy;
        bit acc;
        bit pop;
        @(negedge clk);
        if (init_left > 0) begin
            exp_rdy = 1'b0;
        end else begin
            exp_rdy = req_we || (exp_q.size() < 2) || (exp_q.size() > 0 && rsp_ready);
        end
        check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
        check_eq("busy", 32'(busy), 32'(init_left > 0));
        check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() > 0));
        check_eq("rsp_rdata", rsp_rdata, (exp_q.size() > 0) ? exp_q[0] : last_rd);
        acc = req_valid && exp_rdy;
        pop = (exp_q.size() > 0) && rsp_ready;
        @(posedge clk);
        #1;
        last_acc = acc;
        if (init_left > 0) begin
            init_left--;
        end else begin
            if (pop) last_rd = exp_q.pop_front();
            if (acc) begin
                if (req_we) begin
                    for (int i = 0; i < 4; i++)
                        if (req_be[i]) model_mem[req_addr][i*8 +: 8] = req_wdata[i*8 +: 8];
                end else begin
                    exp_q.push_back(model_mem[req_addr]);
                end
            end
        end
    endtask

    task automatic issue(bit we, logic [3:0] a, logic [31:0] d, logic [3:0] be);
        req_valid = 1'b1;
        req_we = we;
        req_addr = a;
        req_wdata = d;
        req_be = be;
        last_acc = 1'b0;
        for (int i = 0; i < 20 && !last_acc; i++) step();
        if (!last_acc) check_eq("issue_timeout", 32'd0, 32'd1);
        $display("txn we=%0d addr=%0h wdata=%h be=%b acc=%0d", we, a, d, be, last_acc);
        req_valid = 1'b0;
    endtask

    task automatic idle(int n);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(int cycles);
        rst = 1'b1;
        req_valid = 1'b0;
        #1;
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd1);
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        last_rd = '0;
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        init_left = 16;
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Power-up reset, full sweep, then every word reads zero.
        do_reset(3);
        idle(16);
        rsp_ready = 1'b1;
        for (int a = 0; a < 16; a++) issue(1'b0, 4'(a), '0, '0);
        idle(2);

        // Byte-lane writes.
        issue(1'b1, 4'd3, 32'hDEADBEEF, 4'b1111);
        issue(1'b1, 4'd3, 32'h0000AA00, 4'b0010);
        issue(1'b0, 4'd3, '0, '0);
        check_eq("t2_lane_rd", rsp_rdata, 32'hDEADAAEF);
        issue(1'b1, 4'd3, 32'hFFFFFFFF, 4'b0000);
        issue(1'b0, 4'd3, '0, '0);
        check_eq("t2_be0_rd", rsp_rdata, 32'hDEADAAEF);
        idle(2);

        // Back-to-back reads with a free-running consumer.
        for (int a = 0; a < 8; a++) issue(1'b1, 4'(a), 32'h1000_0000 + 32'(a) * 32'h0101, 4'hF);
        for (int a = 0; a < 8; a++) issue(1'b0, 4'(a), '0, '0);
        idle(2);

        // Backpressure: A and B buffer, C stalls until the consumer pops.
        rsp_ready = 1'b0;
        issue(1'b0, 4'd1, '0, '0);
        issue(1'b0, 4'd2, '0, '0);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd4;
        step();
        check_eq("t4_c_stall", 32'(last_acc), 32'd0);
        step();
        check_eq("t4_hold_a", rsp_rdata, 32'h1000_0101);
        rsp_ready = 1'b1;
        step();
        check_eq("t4_c_acc", 32'(last_acc), 32'd1);
        req_valid = 1'b0;
        check_eq("t4_then_b", rsp_rdata, 32'h1000_0202);
        idle(3);

        // Writes proceed while the read FIFO is full.
        rsp_ready = 1'b0;
        issue(1'b0, 4'd6, '0, '0);
        issue(1'b0, 4'd7, '0, '0);
        issue(1'b1, 4'd5, 32'h12345678, 4'hF);
        check_eq("t5_wr_acc", 32'(last_acc), 32'd1);
        rsp_ready = 1'b1;
        idle(3);
        issue(1'b0, 4'd5, '0, '0);
        check_eq("t5_rd", rsp_rdata, 32'h12345678);
        idle(2);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_we = $urandom_range(0, 1);
            req_addr = 4'($urandom_range(0, 15));
            req_wdata = $urandom;
            req_be = 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        idle(1);

        // Reset during the sweep at address 7, and with two responses buffered.
        do_reset(2);
        idle(7);
        do_reset(2);
        idle(16);
        rsp_ready = 1'b0;
        issue(1'b1, 4'd9, 32'hCAFEF00D, 4'hF);
        issue(1'b0, 4'd9, '0, '0);
        issue(1'b0, 4'd9, '0, '0);
        do_reset(2);
        idle(16);
        rsp_ready = 1'b1;
        issue(1'b0, 4'd9, '0, '0);
        check_eq("t6_zeroed", rsp_rdata, 32'd0);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sync_ram_ctrl.md
# sync_ram_ctrl

Parametrised single-port synchronous RAM with a valid/ready request port, per-byte-lane write strobes, a registered 1-cycle read path into a 2-entry response buffer, and an optional post-reset zero-fill sweep. It is the general-purpose memory for the design: CPU and DMA masters issue reads and writes through the request port. Read data returns in order through a backpressurable response port instead of a shared tri-state bus.

## Interface
Parameters:
- ADDR_WIDTH, 13: address bits. Depth is LENGTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32: word width. Must be a multiple of LANE_WIDTH.
- LANE_WIDTH, 8: bits per write-enable lane. NUM_LANES = DATA_WIDTH/LANE_WIDTH.
- INIT_ZERO, 1: 1 = zero-fill all of memory after every reset. 0 = no fill, contents undefined.

Ports:
- clk  in  1  clock. All state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid is also high.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- req_be  in  NUM_LANES  lane write enables. Bit i covers data bits [i*LANE_WIDTH +: LANE_WIDTH].
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes the response this cycle.
- rsp_rdata  out  DATA_WIDTH  read data, head of the response buffer.
- busy  out  1  zero-fill in progress.

## Operation
- The FSM has two states, INIT and RUN.
- Reset:
  - Enters INIT if INIT_ZERO=1, otherwise RUN.
  - Clears the sweep counter, the response buffer count, and the read/write pointers.
- INIT:
  - Writes all-zero to address sweep_cnt each cycle, then increments sweep_cnt.
  - After writing address LENGTH-1, moves to RUN on that same edge.
  - busy is 1 throughout INIT. req_ready is 0.
- RUN, accept condition: a request is accepted when req_valid and req_ready are both high.
- RUN, writes:
  - req_ready = 1 for writes, regardless of response buffer occupancy.
  - The write updates only the lanes whose req_be bit is 1, at the accept edge.
  - req_be = 0 is a legal no-op write.
  - A write produces no response.
- RUN, reads:
  - req_ready = (count < 2) or (rsp_valid and rsp_ready). The combinational path from rsp_ready to req_ready is intentional.
  - mem[req_addr] is sampled at the accept edge and pushed to the buffer tail.
- Response buffer:
  - It is a 2-entry FIFO. Responses are strictly in order.
  - A pop happens when rsp_valid and rsp_ready are both high.
  - A push and a pop on the same edge leave count unchanged.
- Ordering: a read accepted on the edge after a write to the same address returns the new data. Only one request per cycle, so there is no same-cycle conflict.
- Memory contents are not affected by reset itself. Only the INIT sweep clears them.

## Timing
- Reset values:
  - rsp_valid = 0, rsp_rdata = 0, count = 0.
  - busy = INIT_ZERO.
  - req_ready = 0 while rst is high.
  - These take effect immediately on assertion (asynchronous).
- INIT duration: exactly LENGTH cycles after rst deasserts. req_ready can first be 1 in cycle LENGTH+1.
- Read latency: a read accepted in cycle N gives rsp_valid = 1 with its data in cycle N+1.
- Throughput: one read per cycle sustained while rsp_ready = 1.
- Hold rule: while rsp_valid=1 and rsp_ready=0, rsp_rdata and rsp_valid hold stable.
- When the buffer empties, rsp_rdata holds its last value.
- Full buffer (count=2) with rsp_ready=0: reads stall and writes still proceed.
- Reset mid-INIT restarts the sweep from address 0.
- Reset mid-RUN discards any buffered responses.

## Test plan
1. INIT_ZERO=1, ADDR_WIDTH=4, DATA_WIDTH=32. Hold rst for 3 cycles, then release. Require busy=1 and req_ready=0 for exactly 16 cycles. Then read all 16 addresses and require every response to be 0x00000000.
2. Byte-lane write to address 3:
   - Write 0xDEADBEEF with be=4'b1111.
   - Write 0x0000AA00 with be=4'b0010.
   - Read address 3. Require 0xDEADAAEF.
   - Write with be=0, then read again. Require it to still return 0xDEADAAEF.
3. Hold rsp_ready=1 and issue reads of addresses 0..7 back-to-back. Require:
   - req_ready=1 every cycle.
   - rsp_valid in cycles N+1..N+8.
   - Data in address order.
   - No bubbles.
4. Hold rsp_ready=0 and issue reads A, B, C. Require:
   - A and B accepted, C stalled with req_ready=0.
   - rsp_rdata holds A's data.
   - Then raise rsp_ready for one cycle: C is accepted in that same cycle, and A pops.
   - Responses then come out in the order B, C.
5. With the buffer full (count=2) and rsp_ready=0, write 0x12345678 to address 5 with be=4'hF. Require req_ready=1 for the write. After draining, read address 5 and require 0x12345678.
6. Assert rst at sweep address 7 of INIT, and separately with 2 responses buffered in RUN. Require:
   - rsp_valid drops immediately.
   - busy=1.
   - A full 16-cycle sweep follows after release.
